// File: rtl/siso_phase_sequencer_if.sv
// Control/status bundle between the HDSISO8 phase sequencer and its controller.
// The sequencer side is the slave; the controller (or bench) side is the master.
interface siso_phase_sequencer_if #(
  parameter int CNT_W = 4
);
  logic             RUN;
  logic             STEP;
  logic             HOLD;
  logic             CLEAR;
  logic             SHOW_LFSR;
  logic [7:0]       LFSR_STATE;
  logic [3:0]       JOHNSON;
  logic [7:0]       PULSES;
  logic             SHIFT_TICK;
  logic [CNT_W-1:0] BIT_COUNT;
  logic             FULL;
  logic             BUSY;
  logic [7:0]       UIO_OUT;

  modport master (
    output RUN, STEP, HOLD, CLEAR, SHOW_LFSR, LFSR_STATE,
    input  JOHNSON, PULSES, SHIFT_TICK, BIT_COUNT, FULL, BUSY, UIO_OUT
  );

  modport slave (
    input  RUN, STEP, HOLD, CLEAR, SHOW_LFSR, LFSR_STATE,
    output JOHNSON, PULSES, SHIFT_TICK, BIT_COUNT, FULL, BUSY, UIO_OUT
  );
endinterface

// File: rtl/siso_phase_sequencer.sv
// Phase sequencer for the HDSISO8 datapath: 8-phase Johnson count, one-hot phase
// pulses, per-round shift strobe, saturating bit counter and uio_out selection.
module siso_phase_sequencer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  siso_phase_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_STOPPING
  } state_t;

  localparam logic [3:0]       JOHNSON_LAST = 4'b1000;
  localparam logic [CNT_W-1:0] COUNT_FULL   = CNT_W'(DEPTH);

  state_t           state_q, state_d;
  logic [3:0]       johnson_q, johnson_d;
  logic [7:0]       pulses_q, pulses_d;
  logic             shift_tick_q, shift_tick_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic             busy_q, busy_d;
  logic             step_d_q, step_d_d;

  logic             step_re;
  logic             wrap;
  logic             advance;
  logic [3:0]       johnson_nxt;

  // Shift left, feeding back the inverted MSB: one bit flips per advance.
  function automatic logic [3:0] johnson_next(input logic [3:0] j);
    return {j[2:0], ~j[3]};
  endfunction

  function automatic logic [7:0] johnson_onehot(input logic [3:0] j);
    logic [7:0] oh;
    case (j)
      4'b0000: oh = 8'h01;
      4'b0001: oh = 8'h02;
      4'b0011: oh = 8'h04;
      4'b0111: oh = 8'h08;
      4'b1111: oh = 8'h10;
      4'b1110: oh = 8'h20;
      4'b1100: oh = 8'h40;
      4'b1000: oh = 8'h80;
      default: oh = 8'h00;
    endcase
    return oh;
  endfunction

  assign step_re     = bus.STEP & ~step_d_q;
  assign wrap        = (johnson_q == JOHNSON_LAST);
  assign johnson_nxt = johnson_next(johnson_q);

  always_comb begin
    state_d      = state_q;
    johnson_d    = johnson_q;
    pulses_d     = pulses_q;
    shift_tick_d = 1'b0;
    busy_d       = busy_q;
    step_d_d     = bus.STEP;
    advance      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.RUN || step_re) begin
          state_d   = bus.RUN ? S_RUN : S_STEP;
          johnson_d = 4'b0000;
          pulses_d  = 8'h01;
          busy_d    = 1'b1;
        end
      end

      default: begin
        // HOLD freezes phase and state; control inputs wait until it drops.
        if (!bus.HOLD) begin
          advance      = 1'b1;
          johnson_d    = johnson_nxt;
          pulses_d     = johnson_onehot(johnson_nxt);
          shift_tick_d = wrap;

          if (bus.RUN) begin
            state_d = S_RUN;
          end else if (wrap) begin
            // Round complete with no RUN request: park on phase 0.
            state_d   = S_IDLE;
            johnson_d = 4'b0000;
            pulses_d  = 8'h00;
            busy_d    = 1'b0;
          end else if (state_q == S_RUN) begin
            state_d = S_STOPPING;
          end
        end
      end
    endcase
  end

  always_comb begin
    bit_count_d = bit_count_q;
    if (bus.CLEAR) begin
      bit_count_d = '0;
    end else if (advance && wrap && (bit_count_q != COUNT_FULL)) begin
      bit_count_d = bit_count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      johnson_q    <= 4'b0000;
      pulses_q     <= 8'h00;
      shift_tick_q <= 1'b0;
      bit_count_q  <= '0;
      busy_q       <= 1'b0;
      step_d_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      johnson_q    <= johnson_d;
      pulses_q     <= pulses_d;
      shift_tick_q <= shift_tick_d;
      bit_count_q  <= bit_count_d;
      busy_q       <= busy_d;
      step_d_q     <= step_d_d;
    end
  end

  assign bus.JOHNSON    = johnson_q;
  assign bus.PULSES     = pulses_q;
  assign bus.SHIFT_TICK = shift_tick_q;
  assign bus.BIT_COUNT  = bit_count_q;
  assign bus.FULL       = (bit_count_q == COUNT_FULL);
  assign bus.BUSY       = busy_q;
  assign bus.UIO_OUT    = bus.SHOW_LFSR ? bus.LFSR_STATE : pulses_q;

endmodule

// File: tb/tb_siso_phase_sequencer.sv
// Directed bench for siso_phase_sequencer: step/run/hold/stop rounds, reset,
// clear-vs-wrap and the uio_out mux, against hand-computed phase tables.
module tb_siso_phase_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;

  logic [3:0] jtab [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                           4'b1111, 4'b1110, 4'b1100, 4'b1000};
  logic [7:0] ptab [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                           8'h10, 8'h20, 8'h40, 8'h80};

  siso_phase_sequencer_if #(.CNT_W(4)) sif ();

  siso_phase_sequencer #(.DEPTH(8), .CNT_W(4)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (sif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_phase(input string tag, input int p);
    chk({tag, "_johnson"}, 32'(sif.JOHNSON), 32'(jtab[p]));
    chk({tag, "_pulses"},  32'(sif.PULSES),  32'(ptab[p]));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_idle_johnson"}, 32'(sif.JOHNSON), 32'h0);
    chk({tag, "_idle_pulses"},  32'(sif.PULSES),  32'h0);
    chk({tag, "_idle_busy"},    32'(sif.BUSY),    32'h0);
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int n = 0;
    while (sif.BUSY && n < max_cycles) begin
      tick();
      n++;
    end
    chk({tag, "_idle_timeout"}, 32'(sif.BUSY), 32'h0);
  endtask

  initial begin
    int p;
    int exp_cnt;
    int len;

    sif.RUN = 1'b0; sif.STEP = 1'b0; sif.HOLD = 1'b0; sif.CLEAR = 1'b0;
    sif.SHOW_LFSR = 1'b0; sif.LFSR_STATE = 8'h00;

    tick(); tick();
    rst = 1'b0;
    chk_idle("reset");
    chk("reset_tick",  32'(sif.SHIFT_TICK), 32'h0);
    chk("reset_count", 32'(sif.BIT_COUNT),  32'h0);
    chk("reset_full",  32'(sif.FULL),       32'h0);

    // 1: single step round
    sif.STEP = 1'b1; tick(); sif.STEP = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_phase("step", i);
      chk("step_busy", 32'(sif.BUSY), 32'h1);
      chk("step_tick", 32'(sif.SHIFT_TICK), 32'h0);
      tick();
    end
    chk_idle("step_end");
    chk("step_end_tick",  32'(sif.SHIFT_TICK), 32'h1);
    chk("step_end_count", 32'(sif.BIT_COUNT),  32'h1);
    tick();
    chk("step_after_tick", 32'(sif.SHIFT_TICK), 32'h0);

    // 2: continuous run with saturation, then stop mid-round
    exp_cnt = 1;
    sif.RUN = 1'b1; tick();
    p = 0;
    chk_phase("run_entry", 0);
    for (int i = 0; i < 70; i++) begin
      tick();
      p = (p + 1) % 8;
      if (p == 0 && exp_cnt < 8) exp_cnt++;
      chk_phase("run", p);
      chk("run_tick",  32'(sif.SHIFT_TICK), (p == 0) ? 32'h1 : 32'h0);
      chk("run_count", 32'(sif.BIT_COUNT),  32'(exp_cnt));
      chk("run_full",  32'(sif.FULL),       (exp_cnt == 8) ? 32'h1 : 32'h0);
    end
    while (p != 3) begin
      tick();
      p = (p + 1) % 8;
    end
    chk_phase("stop_at", 3);
    sif.RUN = 1'b0;
    for (int i = 4; i < 8; i++) begin
      tick();
      chk_phase("stopping", i);
      chk("stopping_busy", 32'(sif.BUSY), 32'h1);
    end
    tick();
    chk_idle("stop_end");
    chk("stop_end_tick", 32'(sif.SHIFT_TICK), 32'h1);
    chk("stop_end_full", 32'(sif.FULL),       32'h1);

    // 3: hold for 5 edges at phase 5
    sif.RUN = 1'b1; tick();
    len = 0;
    for (int i = 1; i <= 5; i++) begin
      tick(); len++;
    end
    chk_phase("hold_at", 5);
    sif.HOLD = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); len++;
      chk_phase("hold", 5);
      chk("hold_tick", 32'(sif.SHIFT_TICK), 32'h0);
    end
    sif.HOLD = 1'b0;
    tick(); len++;
    chk_phase("hold_resume", 6);
    while (!sif.SHIFT_TICK && len < 40) begin
      tick(); len++;
    end
    chk("hold_round_len", 32'(len), 32'd13);
    chk_phase("hold_wrap", 0);
    sif.RUN = 1'b0;
    wait_idle("hold", 20);

    // 4: simultaneous RUN+STEP enters RUN; extra STEP inside a step round is dropped
    sif.RUN = 1'b1; sif.STEP = 1'b1; tick(); sif.STEP = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk_phase("prio_run", 0);
    chk("prio_busy", 32'(sif.BUSY), 32'h1);
    sif.RUN = 1'b0;
    wait_idle("prio", 20);
    tick();
    sif.STEP = 1'b1; tick(); sif.STEP = 1'b0;
    tick(); tick();
    sif.STEP = 1'b1; tick(); sif.STEP = 1'b0;
    chk_phase("restep", 3);
    for (int i = 0; i < 5; i++) tick();
    chk_idle("restep_end");
    tick(); tick();
    chk_idle("restep_not_queued");

    // 5: reset mid-round, then clear coinciding with a wrap
    sif.CLEAR = 1'b1; tick(); sif.CLEAR = 1'b0;
    chk("clear_count", 32'(sif.BIT_COUNT), 32'h0);
    sif.RUN = 1'b1; tick();
    for (int i = 0; i < 28; i++) tick();
    chk("pre_reset_count", 32'(sif.BIT_COUNT), 32'h3);
    chk_phase("pre_reset", 4);
    rst = 1'b1; sif.RUN = 1'b0; tick(); rst = 1'b0;
    chk_idle("midreset");
    chk("midreset_count", 32'(sif.BIT_COUNT),  32'h0);
    chk("midreset_tick",  32'(sif.SHIFT_TICK), 32'h0);
    tick();
    chk_idle("midreset_stay");

    sif.RUN = 1'b1; tick();
    for (int i = 0; i < 40; i++) tick();
    chk("pre_clear_count", 32'(sif.BIT_COUNT), 32'h5);
    for (int i = 0; i < 7; i++) tick();
    chk_phase("pre_clear", 7);
    sif.CLEAR = 1'b1; tick(); sif.CLEAR = 1'b0;
    chk("clear_wrap_count", 32'(sif.BIT_COUNT),  32'h0);
    chk("clear_wrap_tick",  32'(sif.SHIFT_TICK), 32'h1);

    // 6: uio_out selection at phase 2
    tick(); tick();
    chk_phase("uio_at", 2);
    sif.LFSR_STATE = 8'hA5; sif.SHOW_LFSR = 1'b1; #1;
    chk("uio_lfsr", 32'(sif.UIO_OUT), 32'hA5);
    sif.SHOW_LFSR = 1'b0; #1;
    chk("uio_pulses", 32'(sif.UIO_OUT), 32'h04);
    sif.RUN = 1'b0;
    wait_idle("final", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
